// File: rtl/bresenham_line_drawer.sv
// Line rasteriser feeding a VGA framebuffer: one (x, y, colour) write per clock,
// integer Bresenham with a start/busy/done handshake.
module bresenham_line_drawer #(
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic           color_in,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pixel_color,
    output logic           pixel_write,
    output logic           busy,
    output logic           done
);

    localparam int unsigned W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic [X_W-1:0] XOne = 1;
    localparam logic [Y_W-1:0] YOne = 1;

    typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_e;

    state_e state_q, state_d;

    logic [X_W-1:0] x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
    logic [Y_W-1:0] y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;
    logic           color_q, color_d;
    logic           sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

    logic [X_W-1:0]      xdiff;
    logic [Y_W-1:0]      ydiff;
    logic signed [W-1:0] dx_calc, dy_mag, dy_calc;
    logic signed [W-1:0] e2, err_n;
    logic                at_end;

    // Endpoint distances from the latched segment, used only in StSetup.
    always_comb begin
        xdiff   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ydiff   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        dx_calc = signed'({{(W-X_W){1'b0}}, xdiff});
        dy_mag  = signed'({{(W-Y_W){1'b0}}, ydiff});
        dy_calc = -dy_mag;
        at_end  = (cx_q == x1_q) && (cy_q == y1_q);
    end

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        color_d  = color_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        e2       = err_q <<< 1;
        err_n    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    color_d = color_in;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                dx_d     = dx_calc;
                dy_d     = dy_calc;
                err_d    = dx_calc + dy_calc;
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                cx_d     = x0_q;
                cy_d     = y0_q;
                state_d  = StDraw;
            end
            StDraw: begin
                if (at_end) begin
                    state_d = StDone;
                end else begin
                    // Both tests see the old err so a diagonal step takes one cycle.
                    if (e2 >= dy_q) begin
                        err_n = err_n + dy_q;
                        cx_d  = sx_neg_q ? (cx_q - XOne) : (cx_q + XOne);
                    end
                    if (e2 <= dx_q) begin
                        err_n = err_n + dx_q;
                        cy_d  = sy_neg_q ? (cy_q - YOne) : (cy_q + YOne);
                    end
                    err_d = err_n;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            color_q  <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode straight from registers so reset clears them without a clock.
    always_comb begin
        x           = cx_q;
        y           = cy_q;
        pixel_color = color_q;
        pixel_write = (state_q == StDraw);
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
    end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer with hand-computed pixel lists.
module tb_bresenham_line_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] x0, x1, x;
    logic [8:0] y0, y1, y;
    logic       color_in, pixel_color, pixel_write, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int px[$];
    int py[$];
    int first_c, last_c, done_c;

    bresenham_line_drawer #(.X_W(10), .Y_W(9)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color_in(color_in),
        .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive start for one cycle; returns at the negedge where SETUP is visible.
    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input bit col);
        @(negedge clk);
        x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1);
        color_in = col;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("setup_no_write", int'(pixel_write), 0);
        check_eq("setup_busy", int'(busy), 1);
    endtask

    // Record writes until done; poke keeps start high with another segment while busy.
    task automatic collect(input int budget, input bit poke, input int stop_at, output int n);
        bit got_done = 1'b0;
        n = 0;
        first_c = -1; last_c = -1; done_c = -1;
        px.delete(); py.delete();
        for (int c = 0; c < budget && !got_done; c++) begin
            @(negedge clk);
            if (pixel_write) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                px.push_back(int'(x));
                py.push_back(int'(y));
                n++;
            end
            if (done) begin
                got_done = 1'b1;
                done_c = c;
            end
            if (poke) begin
                start = !got_done;
                x0 = 10'd50; y0 = 9'd50; x1 = 10'd60; y1 = 9'd60;
            end
            if (stop_at > 0 && n == stop_at) return;
        end
        check_eq("done_seen", int'(got_done), 1);
    endtask

    task automatic check_pixels(input string tag, input int ex[$], input int ey[$]);
        check_eq({tag, "_count"}, px.size(), ex.size());
        for (int i = 0; i < ex.size() && i < px.size(); i++) begin
            check_eq($sformatf("%s_x%0d", tag, i), px[i], ex[i]);
            check_eq($sformatf("%s_y%0d", tag, i), py[i], ey[i]);
        end
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b1; start = 1'b0; color_in = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_x", int'(x), 0);
        check_eq("rst_y", int'(y), 0);
        check_eq("rst_pw", int'(pixel_write), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_color", int'(pixel_color), 0);
        reset = 1'b0;

        // Horizontal.
        start_line(0, 0, 5, 0, 1'b0);
        collect(50, 1'b0, 0, n);
        check_pixels("horiz", '{0, 1, 2, 3, 4, 5}, '{0, 0, 0, 0, 0, 0});
        check_eq("horiz_first_lat", first_c, 0);
        check_eq("horiz_done_lat", done_c, last_c + 1);
        @(negedge clk);
        check_eq("horiz_idle_busy", int'(busy), 0);
        check_eq("horiz_hold_x", int'(x), 5);

        // Steep, y-major.
        start_line(10, 10, 12, 20, 1'b0);
        collect(50, 1'b0, 0, n);
        check_pixels("steep", '{10, 10, 10, 11, 11, 11, 11, 11, 12, 12, 12},
                     '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20});

        // Diagonal towards the origin.
        start_line(20, 15, 15, 10, 1'b0);
        collect(50, 1'b0, 0, n);
        check_pixels("diag", '{20, 19, 18, 17, 16, 15}, '{15, 14, 13, 12, 11, 10});

        // Single point, with start held during busy.
        start_line(7, 7, 7, 7, 1'b0);
        collect(50, 1'b1, 0, n);
        check_pixels("point", '{7}, '{7});
        check_eq("point_done_lat", done_c, last_c + 1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (pixel_write || busy) bad++;
        end
        check_eq("point_no_extra", bad, 0);

        // Full-screen diagonal.
        start_line(0, 0, 639, 479, 1'b0);
        collect(2000, 1'b0, 0, n);
        check_eq("full_count", n, 640);
        if (n > 0) begin
            check_eq("full_last_x", px[n-1], 639);
            check_eq("full_last_y", py[n-1], 479);
        end
        bad = 0;
        for (int i = 1; i < n; i++) if (px[i] <= px[i-1]) bad++;
        check_eq("full_x_monotonic", bad, 0);

        // Same line, reset after write 100.
        start_line(0, 0, 639, 479, 1'b1);
        collect(2000, 1'b0, 100, n);
        check_eq("rst_mid_count", n, 100);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_pw", int'(pixel_write), 0);
        check_eq("rst_mid_busy", int'(busy), 0);
        check_eq("rst_mid_done", int'(done), 0);
        check_eq("rst_mid_x", int'(x), 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (pixel_write || done || busy) bad++;
        end
        check_eq("rst_mid_quiet", bad, 0);

        // Back-to-back: next start in the idle cycle right after done.
        start_line(1, 1, 3, 1, 1'b0);
        collect(50, 1'b0, 0, n);
        check_eq("b2b_a_count", n, 3);
        start_line(3, 3, 3, 0, 1'b1);
        collect(50, 1'b0, 0, n);
        check_pixels("b2b_vert", '{3, 3, 3, 3}, '{3, 2, 1, 0});
        check_eq("b2b_color", int'(pixel_color), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
